mealy_d_fsm: RTL and testbench



---
 rtl/mealy_d_fsm.sv | 38 +++
 tb/tb_mealy_d_fsm.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mealy_d_fsm.sv
// mealy_d_fsm: Mealy detector for serial pattern 1-0-1-1, z combinational from state and x.
// Optional saturating match counter enabled by defining MEALY_D_COUNT_EN.
`timescale 1ns/1ps
module mealy_d_fsm #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
`ifdef MEALY_D_COUNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             z
);
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} state_t;
  state_t state, state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S0;
    else        state <= state_nx;
  always_comb begin
    state_nx = S0;
    case (state)
      S0:      state_nx = x ? S1 : S0;
      S1:      state_nx = x ? S1 : S2;
      S2:      state_nx = x ? S3 : S0;
      S3:      state_nx = x ? ((OVERLAP != 0) ? S1 : S0) : S2;
      default: state_nx = S0;
    endcase
  end
  always_comb z = reset & (state == S3) & x;
`ifdef MEALY_D_COUNT_EN
  // Counter holds at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset)
    if (!reset)                 match_cnt <= '0;
    else if (z && ~&match_cnt)  match_cnt <= match_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_mealy_d_fsm.sv
// tb_mealy_d_fsm: scoreboard bench comparing an overlapping and a non-overlapping detector.
`timescale 1ns/1ps
module tb_mealy_d_fsm;
  logic clk = 0, reset = 0, x = 0;
  logic za, zb;
  int   tests = 0, fails = 0;
  bit   qa[$], qb[$];
  bit   ea_z, eb_z;
  int   ea = 0, eb = 0;
`ifdef MEALY_D_COUNT_EN
  logic [7:0] ca;
  logic [1:0] cb;
`endif

  mealy_d_fsm #(.OVERLAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .x(x),
`ifdef MEALY_D_COUNT_EN
    .match_cnt(ca),
`endif
    .z(za));
  mealy_d_fsm #(.OVERLAP(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .x(x),
`ifdef MEALY_D_COUNT_EN
    .match_cnt(cb),
`endif
    .z(zb));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one sample just before every rising edge for each issued bit.
  always @(negedge clk) begin
    #4;
    if (qa.size() != 0) begin
      ea_z = qa.pop_front();
      eb_z = qb.pop_front();
      chk("z_overlap", za, ea_z);
      chk("z_restart", zb, eb_z);
`ifdef MEALY_D_COUNT_EN
      chk("cnt_overlap", ca, ea);
      chk("cnt_restart", cb, eb);
`endif
      if (ea_z && ea < 255) ea++;
      if (eb_z && eb < 3) eb++;
    end
  end

  task automatic send(input logic b, input bit eza, input bit ezb);
    @(negedge clk);
    x = b;
    qa.push_back(eza);
    qb.push_back(ezb);
  endtask

  task automatic stream(input int n, input logic [31:0] xs, input logic [31:0] zs_a, input logic [31:0] zs_b);
    for (int i = n - 1; i >= 0; i--) send(xs[i], zs_a[i], zs_b[i]);
  endtask

  task automatic settle(input logic [1:0] sa, input logic [1:0] sb);
    @(negedge clk);
    #1;
    chk("state_overlap", dut_a.state, sa);
    chk("state_restart", dut_b.state, sb);
`ifdef MEALY_D_COUNT_EN
    chk("cnt_end_overlap", ca, ea);
    chk("cnt_end_restart", cb, eb);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    x = 0;
    ea = 0;
    eb = 0;
    #1;
    chk("rst_z_a", za, 0);
    chk("rst_z_b", zb, 0);
    chk("rst_state", dut_a.state, 0);
`ifdef MEALY_D_COUNT_EN
    chk("rst_cnt_a", ca, 0);
    chk("rst_cnt_b", cb, 0);
`endif
    #2 x = 1;
    #1;
    chk("rst_xtog_a", za, 0);
    chk("rst_xtog_b", zb, 0);
    @(negedge clk);
    x = 0;
    reset = 1;
  endtask

  initial begin
    do_reset();
    stream(6, 32'b101101, 32'b000100, 32'b000100);
    settle(2'b11, 2'b01);
    do_reset();
    stream(7, 32'b1011011, 32'b0001001, 32'b0001000);
    settle(2'b01, 2'b01);
    do_reset();
    stream(11, 32'b10011101011, 32'b00000000001, 32'b00000000001);
    settle(2'b01, 2'b00);
    do_reset();
    stream(3, 32'b101, 32'b000, 32'b000);
    @(negedge clk);
    x = 1;
    #1;
    chk("pre_async_a", za, 1);
    chk("pre_async_b", zb, 1);
    reset = 0;
    #1;
    chk("async_z_a", za, 0);
    chk("async_z_b", zb, 0);
    chk("async_state", dut_a.state, 0);
    ea = 0;
    eb = 0;
    @(negedge clk);
    x = 0;
    reset = 1;
    stream(4, 32'b1011, 32'b0001, 32'b0001);
    settle(2'b01, 2'b00);
    do_reset();
    stream(20, 32'hBBBBB, 32'h11111, 32'h11111);
    settle(2'b01, 2'b00);
`ifdef MEALY_D_COUNT_EN
    chk("sat_a", ca, 5);
    chk("sat_b", cb, 3);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
